// File: rtl/led_matrix_scan_ctrl.sv
// led_matrix_scan_ctrl
// Refresh controller for a 64x32 HUB75 panel at 1/16 scan with 4-plane
// binary code modulation. For each scan row and bit-plane it fetches the
// upper-half and lower-half pixels of every column from a combinational
// pixel source, shifts them out on r1/g1/b1 and r2/g2/b2 with panel_clk,
// latches the row, and then enables the LEDs for BASE_TIME<<plane cycles.
//
// Ports:
//   clk, rst      system clock; synchronous active-high reset
//   enable        run refresh; only looked at on frame boundaries
//   pixel_addr    {1'b0, row[4:0], col[5:0]} to the pixel source
//   pixel_data    {R,G,B} 8 bits each, valid in the same cycle as pixel_addr
//   r1,g1,b1      upper-half shift data
//   r2,g2,b2      lower-half shift data
//   panel_clk     HUB75 shift clock
//   lat           HUB75 latch, active-high
//   oe_n          HUB75 output enable, active-low
//   row_addr      HUB75 A..D scan row
//   frame_start   one-cycle pulse in the first fetch cycle of every frame
module led_matrix_scan_ctrl #(
  parameter int unsigned COLS      = 64,
  parameter int unsigned SCAN_ROWS = 16,
  parameter int unsigned PLANES    = 4,
  parameter int unsigned BASE_TIME = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [11:0] pixel_addr,
  input  logic [23:0] pixel_data,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic        panel_clk,
  output logic        lat,
  output logic        oe_n,
  output logic [3:0]  row_addr,
  output logic        frame_start
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(SCAN_ROWS);
  localparam int unsigned PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int unsigned DW = $clog2((BASE_TIME << (PLANES - 1)) + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_TOP,
    FETCH_BOT,
    CLK_LO,
    CLK_HI,
    LATCH,
    DISPLAY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [DW-1:0]   disp_q, disp_d;
  logic [2:0]      top_q, top_d;

  logic [11:0]     pixel_addr_q, pixel_addr_d;
  logic [5:0]      rgb_q, rgb_d;
  logic            panel_clk_q, panel_clk_d;
  logic            lat_q, lat_d;
  logic            oe_n_q, oe_n_d;
  logic [3:0]      row_addr_q, row_addr_d;
  logic            frame_start_q, frame_start_d;

  // Plane p of a channel is bit (8-PLANES)+p, i.e. the PLANES MSBs.
  logic [PLANES-1:0] r_pl, g_pl, b_pl;
  logic [2:0]        cur_bits;
  logic [DW-1:0]     disp_len;
  logic              disp_last;
  logic              unused_pixel_bits;

  assign r_pl     = pixel_data[23 -: PLANES];
  assign g_pl     = pixel_data[15 -: PLANES];
  assign b_pl     = pixel_data[7 -: PLANES];
  assign cur_bits = {r_pl[plane_q], g_pl[plane_q], b_pl[plane_q]};
  assign unused_pixel_bits = ^pixel_data;

  assign disp_len  = DW'(BASE_TIME) << plane_q;
  assign disp_last = (disp_q == disp_len - DW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      disp_q        <= '0;
      top_q         <= '0;
      pixel_addr_q  <= '0;
      rgb_q         <= '0;
      panel_clk_q   <= 1'b0;
      lat_q         <= 1'b0;
      oe_n_q        <= 1'b1;
      row_addr_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      disp_q        <= disp_d;
      top_q         <= top_d;
      pixel_addr_q  <= pixel_addr_d;
      rgb_q         <= rgb_d;
      panel_clk_q   <= panel_clk_d;
      lat_q         <= lat_d;
      oe_n_q        <= oe_n_d;
      row_addr_q    <= row_addr_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    plane_d       = plane_q;
    disp_d        = disp_q;
    top_d         = top_q;
    rgb_d         = rgb_q;
    pixel_addr_d  = pixel_addr_q;
    row_addr_d    = row_addr_q;
    frame_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d       = FETCH_TOP;
          col_d         = '0;
          row_d         = '0;
          plane_d       = '0;
          frame_start_d = 1'b1;
        end
      end
      FETCH_TOP: begin
        top_d   = cur_bits;
        state_d = FETCH_BOT;
      end
      FETCH_BOT: begin
        // Upper bits were held from the previous cycle so all six data
        // lines change together.
        rgb_d   = {top_q, cur_bits};
        state_d = CLK_LO;
      end
      CLK_LO: begin
        state_d = CLK_HI;
      end
      CLK_HI: begin
        if (col_q == CW'(COLS - 1)) begin
          state_d = LATCH;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = FETCH_TOP;
        end
      end
      LATCH: begin
        disp_d  = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (disp_last) begin
          col_d = '0;
          if (plane_q != PW'(PLANES - 1)) begin
            plane_d = plane_q + PW'(1);
            state_d = FETCH_TOP;
          end else if (row_q != RW'(SCAN_ROWS - 1)) begin
            plane_d = '0;
            row_d   = row_q + RW'(1);
            state_d = FETCH_TOP;
          end else begin
            plane_d = '0;
            row_d   = '0;
            if (enable) begin
              state_d       = FETCH_TOP;
              frame_start_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          disp_d = disp_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the
    // state they belong to rather than lagging it by a cycle.
    panel_clk_d = (state_d == CLK_HI);
    lat_d       = (state_d == LATCH);
    oe_n_d      = (state_d != DISPLAY);
    if (state_d == LATCH) begin
      row_addr_d = 4'(row_q);
    end
    if (state_d == FETCH_TOP) begin
      pixel_addr_d = 12'({2'b00, row_d, col_d});
    end else if (state_d == FETCH_BOT) begin
      pixel_addr_d = 12'({2'b01, row_q, col_q});
    end
  end

  assign pixel_addr  = pixel_addr_q;
  assign {r1, g1, b1, r2, g2, b2} = rgb_q;
  assign panel_clk   = panel_clk_q;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign row_addr    = row_addr_q;
  assign frame_start = frame_start_q;

endmodule
